systolic_feeder: RTL and testbench

//  Upstream stage of the systolic multiplier. Stores two NxN operand matrices A and B,

---
 rtl/systolic_pkg.sv | 24 ++
 rtl/systolic_feeder_bank.sv | 57 +++++
 rtl/systolic_feeder.sv | 144 ++++++++++++++
 tb/tb_systolic_feeder.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared types and sizing helpers for the systolic feeder.
//   feeder_state_e : job sequencer states
//   DEF_N/DEF_WIDTH: default matrix dimension and element width
//   idx_w/t_w/lat_w: widths of row index, stream step and drain-timeout counter
package systolic_pkg;

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} feeder_state_e;

  localparam int DEF_N     = 4;
  localparam int DEF_WIDTH = 4;

  function automatic int idx_w(input int n);
    return $clog2(n);
  endfunction

  function automatic int t_w(input int n);
    return $clog2(2 * n);
  endfunction

  function automatic int lat_w(input int n);
    return $clog2(n * n + 3);
  endfunction

endpackage

// File: rtl/systolic_feeder_bank.sv
// Operand bank: N rows of A and N columns of B, one write port, and a
// combinational skewed read of all 2N edge lanes for stream step t.
// Ports:
//   clk, rst_n        clock, async active-low reset (contents clear to 0)
//   wr_en             write strobe
//   wr_mat            0 = A row, 1 = B column
//   wr_idx            row of A / column of B
//   wr_data           element k at [k*WIDTH +: WIDTH]
//   t                 stream step
//   x_lane[i]         A[i][t-i], 0 when out of range
//   y_lane[j]         B[t-j][j], 0 when out of range
module systolic_feeder_bank
  import systolic_pkg::*;
#(
  parameter int N     = DEF_N,
  parameter int WIDTH = DEF_WIDTH,
  localparam int IDXW = idx_w(N),
  localparam int TW   = t_w(N)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        wr_en,
  input  logic                        wr_mat,
  input  logic [IDXW-1:0]             wr_idx,
  input  logic [N*WIDTH-1:0]          wr_data,
  input  logic [TW-1:0]               t,
  output logic [N-1:0][WIDTH-1:0]     x_lane,
  output logic [N-1:0][WIDTH-1:0]     y_lane
);

  // a_row[i][k] = A[i][k]; b_col[j][k] = B[k][j]
  logic [N-1:0][N-1:0][WIDTH-1:0] a_row;
  logic [N-1:0][N-1:0][WIDTH-1:0] b_col;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_row <= '0;
      b_col <= '0;
    end else if (wr_en) begin
      if (wr_mat) b_col[wr_idx] <= wr_data;
      else        a_row[wr_idx] <= wr_data;
    end
  end

  // Both edges use the same inner index t-lane, so one range test serves x and y.
  always_comb begin
    x_lane = '0;
    y_lane = '0;
    for (int i = 0; i < N; i++) begin
      if (int'(t) >= i && int'(t) - i < N) begin
        x_lane[i] = a_row[i][IDXW'(int'(t) - i)];
        y_lane[i] = b_col[i][IDXW'(int'(t) - i)];
      end
    end
  end

endmodule

// File: rtl/systolic_feeder.sv
// Systolic feeder: holds operands A and B, streams them diagonally skewed into
// the array edge with a start pulse, waits for the array, then pulses done.
// Optional build macro SYSTOLIC_FEEDER_DBLBUF_EN: two operand banks that swap
// on job start so loading can overlap a running job.
// Ports:
//   clk, rst_n              clock, async active-low reset
//   ld_valid/ld_ready       load handshake (write on valid & ready)
//   ld_mat, ld_idx, ld_data load target (0=A row, 1=B column), index, elements
//   go                      job start request, honoured only in IDLE
//   busy                    job streaming or draining
//   done                    one-cycle job-complete pulse
//   sa_start                array start, high with stream step 0
//   sa_array                [0][i] x lane row i, [1][j] y lane column j
//   sa_finish               array finish (sticky)
//
// state  | meaning
// IDLE   | waiting for go, loads accepted
// STREAM | driving skewed operands, steps 0..2N-2
// DRAIN  | edge idle, waiting for finish rise or timeout
// DONE   | done pulse
module systolic_feeder
  import systolic_pkg::*;
#(
  parameter int N     = DEF_N,
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            ld_valid,
  output logic                            ld_ready,
  input  logic                            ld_mat,
  input  logic [idx_w(N)-1:0]             ld_idx,
  input  logic [N*WIDTH-1:0]              ld_data,
  input  logic                            go,
  output logic                            busy,
  output logic                            done,
  output logic                            sa_start,
  output logic [1:0][N-1:0][WIDTH-1:0]    sa_array,
  input  logic                            sa_finish
);

  localparam int TW   = t_w(N);
  localparam int LATW = lat_w(N);

  feeder_state_e            state, state_nxt;
  logic [TW-1:0]            t, t_nxt;
  logic [LATW-1:0]          lat_cnt;
  logic                     go_q, go_acc, finish_q, finish_rise, wr_en, ld_ready_nxt;
  logic [N-1:0][WIDTH-1:0]  x_rd, y_rd;

  // go is captured once into go_q; the FSM acts on go_q so that outputs,
  // computed from the next state, appear one cycle after the go edge.
  assign go_acc      = go && (state == IDLE) && !go_q;
  assign finish_rise = sa_finish && !finish_q;
  assign wr_en       = ld_valid && ld_ready;

`ifdef SYSTOLIC_FEEDER_DBLBUF_EN
  // bank_sel is the read bank; the other bank takes loads.
  logic                     bank_sel;
  logic [N-1:0][WIDTH-1:0]  x0, y0, x1, y1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      bank_sel <= 1'b0;
    else if (go_acc) bank_sel <= ~bank_sel;
  end

  systolic_feeder_bank #(.N(N), .WIDTH(WIDTH)) u_bank0 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en && bank_sel), .wr_mat(ld_mat),
    .wr_idx(ld_idx), .wr_data(ld_data), .t(t_nxt), .x_lane(x0), .y_lane(y0)
  );
  systolic_feeder_bank #(.N(N), .WIDTH(WIDTH)) u_bank1 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en && !bank_sel), .wr_mat(ld_mat),
    .wr_idx(ld_idx), .wr_data(ld_data), .t(t_nxt), .x_lane(x1), .y_lane(y1)
  );

  assign x_rd         = bank_sel ? x1 : x0;
  assign y_rd         = bank_sel ? y1 : y0;
  assign ld_ready_nxt = 1'b1;
`else
  systolic_feeder_bank #(.N(N), .WIDTH(WIDTH)) u_bank (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_mat(ld_mat),
    .wr_idx(ld_idx), .wr_data(ld_data), .t(t_nxt), .x_lane(x_rd), .y_lane(y_rd)
  );

  // Close the load port on the go edge so the streamed bank cannot change mid-job.
  assign ld_ready_nxt = (state_nxt == IDLE) && !go_acc;
`endif

  always_comb begin
    state_nxt = state;
    t_nxt     = t;
    unique case (state)
      IDLE: begin
        if (go_q) begin
          state_nxt = STREAM;
          t_nxt     = '0;
        end
      end
      STREAM: begin
        if (t == TW'(2 * N - 2)) begin
          state_nxt = DRAIN;
          t_nxt     = '0;
        end else begin
          t_nxt = t + TW'(1);
        end
      end
      DRAIN: begin
        // Timeout path also covers a finish that was already high at go.
        if (finish_rise || lat_cnt == '0) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      t        <= '0;
      lat_cnt  <= '0;
      go_q     <= 1'b0;
      finish_q <= 1'b0;
      ld_ready <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      sa_start <= 1'b0;
      sa_array <= '0;
    end else begin
      state    <= state_nxt;
      t        <= t_nxt;
      go_q     <= go_acc;
      finish_q <= sa_finish;
      ld_ready <= ld_ready_nxt;
      // Timeout down-counter loads on the sa_start cycle.
      if (state == IDLE && state_nxt == STREAM) lat_cnt <= LATW'(N * N + 2);
      else if (lat_cnt != '0)                   lat_cnt <= lat_cnt - LATW'(1);
      busy     <= (state_nxt == STREAM) || (state_nxt == DRAIN);
      done     <= (state_nxt == DONE);
      sa_start <= (state == IDLE) && (state_nxt == STREAM);
      sa_array <= (state_nxt == STREAM) ? {y_rd, x_rd} : '0;
    end
  end

endmodule

// File: tb/tb_systolic_feeder.sv
module tb_systolic_feeder;

  localparam int N = 4;
  localparam int W = 4;

`ifdef SYSTOLIC_FEEDER_DBLBUF_EN
  localparam bit READY_BUSY = 1'b1;
  localparam logic [15:0] JOB2_X_T3 = 16'h3333;
`else
  localparam bit READY_BUSY = 1'b0;
  localparam logic [15:0] JOB2_X_T3 = 16'h0000;
`endif

  logic                       clk;
  logic                       rst_n;
  logic                       ld_valid;
  logic                       ld_ready;
  logic                       ld_mat;
  logic [1:0]                 ld_idx;
  logic [N*W-1:0]             ld_data;
  logic                       go;
  logic                       busy;
  logic                       done;
  logic                       sa_start;
  logic [1:0][N-1:0][W-1:0]   sa_array;
  logic                       sa_finish;

  logic [1:0][N-1:0][W-1:0]   cap [2*N-1];

  int n_vec = 0;
  int n_bad = 0;

  systolic_feeder #(.N(N), .WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_mat(ld_mat), .ld_idx(ld_idx), .ld_data(ld_data), .go(go),
    .busy(busy), .done(done), .sa_start(sa_start), .sa_array(sa_array),
    .sa_finish(sa_finish)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N*W-1:0] a_row(input int kind, input int i);
    logic [N*W-1:0] r;
    r = '0;
    for (int k = 0; k < N; k++) r[k*W +: W] = (kind == 0) ? W'(i == k) : W'(i + k);
    return r;
  endfunction

  // column j of B, B[r][c] = r*4+c
  function automatic logic [N*W-1:0] b_col(input int j);
    logic [N*W-1:0] r;
    r = '0;
    for (int k = 0; k < N; k++) r[k*W +: W] = W'(k * 4 + j);
    return r;
  endfunction

  // Product each array cell would accumulate from the captured skewed edges.
  function automatic logic [63:0] c_from_cap();
    logic [63:0] c;
    int s;
    c = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        s = 0;
        for (int k = 0; k < N; k++) s += int'(cap[i+k][0][i]) * int'(cap[k+j][1][j]);
        c[(i*4+j)*4 +: 4] = 4'(s);
      end
    return c;
  endfunction

  task automatic load(input bit mat, input int idx, input logic [N*W-1:0] data);
    ld_valid = 1'b1;
    ld_mat   = mat;
    ld_idx   = 2'(idx);
    ld_data  = data;
    chk("ld_ready_idle", ld_ready, 1);
    tick();
    ld_valid = 1'b0;
  endtask

  task automatic load_mats(input int kind);
    for (int i = 0; i < N; i++) load(1'b0, i, a_row(kind, i));
    for (int j = 0; j < N; j++) load(1'b1, j, b_col(j));
  endtask

  task automatic run_job(input bit fin_pre, input int fin_at, input bit extra_go,
                         input bit drain_load, output int done_cyc);
    int idx;
    sa_finish = fin_pre;
    if (fin_pre) tick();
    go = 1'b1;
    tick();
    go = 1'b0;
    done_cyc = -1;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (c <= 2*N-1) cap[c-1] = sa_array;
      if (c == 1) begin
        chk("start_t0", sa_start, 1);
        chk("busy_t0", busy, 1);
      end
      if (c == 2) chk("start_t1", sa_start, 0);
      if (c == 3) chk("ready_busy", ld_ready, READY_BUSY);
      if (c == 8) chk("drain_zero", sa_array, 0);
      if (fin_at != 0 && c == fin_at) sa_finish = 1'b1;
      if (extra_go) go = (c == 5 || c == 10);
      if (drain_load) begin
        if (c >= 9 && c <= 16) begin
          idx      = (c - 9) % 4;
          ld_valid = 1'b1;
          ld_mat   = (c >= 13);
          ld_idx   = 2'(idx);
          ld_data  = (c >= 13) ? b_col(idx) : a_row(1, idx);
        end else begin
          ld_valid = 1'b0;
        end
      end
      if (done) begin
        done_cyc = c;
        break;
      end
    end
    ld_valid = 1'b0;
    if (extra_go) go = 1'b1;
    tick();
    go = 1'b0;
    chk("done_1cyc", done, 0);
    sa_finish = 1'b0;
  endtask

  task automatic watch_idle(input string tag);
    int nb;
    nb = 0;
    repeat (25) begin
      tick();
      if (busy || done || sa_start) nb++;
    end
    chk(tag, nb, 0);
  endtask

  initial begin
    int dc;
    rst_n = 1'b0; ld_valid = 1'b0; ld_mat = 1'b0; ld_idx = '0; ld_data = '0;
    go = 1'b0; sa_finish = 1'b0;
    #12;
    chk("rst_outs", {busy, done, sa_start, sa_array}, 0);
    chk("rst_ready", ld_ready, 1);
    tick();
    rst_n = 1'b1;
    tick();

    // identity A, B[r][c]=r*4+c, finish rises in DRAIN
    load_mats(0);
    run_job(1'b0, 8, 1'b0, 1'b0, dc);
    chk("t1_done_rise", dc, 9);
    chk("t1_x_t0", cap[0][0], 16'h0001);
    chk("t1_y_t0", cap[0][1], 16'h0000);
    chk("t1_y_t3", cap[3][1], 16'h369C);
    chk("t1_c_eq_b", c_from_cap(), 64'hFEDCBA9876543210);

    // A[i][k]=i+k, diagonal values
    load_mats(1);
    run_job(1'b0, 8, 1'b0, 1'b0, dc);
    chk("t2_x_t3", cap[3][0], 16'h3333);
    chk("t2_x_t6", cap[6][0], 16'h6000);

    // finish already high before go -> timeout path
    run_job(1'b1, 0, 1'b0, 1'b0, dc);
    chk("t3_done_pre", dc, 20);

    // no finish at all, extra go pulses while busy and in DONE
    run_job(1'b0, 0, 1'b1, 1'b0, dc);
    chk("t4_done_cnt", dc, 20);
    watch_idle("t4_no_requeue");

    // reset mid-stream
    load_mats(0);
    go = 1'b1;
    tick();
    go = 1'b0;
    repeat (3) tick();
    chk("t5_busy_pre", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_outs", {busy, done, sa_start, sa_array}, 0);
    chk("t5_rst_ready", ld_ready, 1);
    tick();
    tick();
    rst_n = 1'b1;
    watch_idle("t5_no_done");
    load_mats(0);
    run_job(1'b0, 8, 1'b0, 1'b0, dc);
    chk("t5_done_rise", dc, 9);
    chk("t5_c_eq_b", c_from_cap(), 64'hFEDCBA9876543210);

    // loads during DRAIN: taken only with double buffering
    load_mats(0);
    run_job(1'b0, 0, 1'b0, 1'b1, dc);
    chk("t6_done_cnt", dc, 20);
    chk("t6_job1_x_t0", cap[0][0], 16'h0001);
    run_job(1'b0, 8, 1'b0, 1'b0, dc);
    chk("t6_job2_x_t3", cap[3][0], JOB2_X_T3);
    chk("t6_job2_y_t3", cap[3][1], 16'h369C);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
